// File: rtl/mdu_iterative.sv
// Iterative unsigned multiply/divide unit: shift-add multiply and restoring divide,
// one bit per cycle, with a start/busy/done handshake and a fixed DATAWIDTH-cycle latency.
module mdu_iterative #(
  parameter int DATAWIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [1:0]           op,
  input  logic [DATAWIDTH-1:0] op_a,
  input  logic [DATAWIDTH-1:0] op_b,
  output logic                 busy,
  output logic                 done,
  output logic [DATAWIDTH-1:0] result,
  output logic                 div_by_zero
);

  // state | meaning
  // IDLE  | waiting for start
  // RUN   | iterating, one bit per cycle for DATAWIDTH cycles
  // DONE  | result valid for one cycle; start here is accepted back-to-back

  localparam int W  = DATAWIDTH;
  localparam int CW = $clog2(DATAWIDTH);

  localparam logic [1:0] OP_MUL   = 2'b00;
  localparam logic [1:0] OP_MULHU = 2'b01;
  localparam logic [1:0] OP_DIVU  = 2'b10;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt;
  logic [1:0]      op_q;
  logic [W-1:0]    a_q;
  logic [W-1:0]    b_q;
  logic [2*W-1:0]  acc;
  logic            accept;
  logic            last;

  logic [W:0]      mul_sum;
  logic [2*W-1:0]  mul_acc;
  logic [W:0]      div_shift;
  logic [W:0]      div_diff;
  logic            div_ge;
  logic [W:0]      div_rem;
  logic [W-1:0]    div_quo;
  logic [W-1:0]    res_sel;

  assign accept = start && (state != RUN);
  assign last   = (state == RUN) && (cnt == CW'(W - 1));
  assign busy   = (state == RUN);
  assign done   = (state == DONE);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last)  state_nxt = DONE;
      DONE:    state_nxt = start ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Multiply: acc holds {partial product high, multiplier-shifted low}; b_q supplies bits LSB-first.
  // Divide: acc[W:0] is the partial remainder; a_q shifts the dividend out and the quotient in.
  // A zero divisor naturally yields an all-ones quotient and remainder equal to the dividend.
  always_comb begin
    mul_sum   = {1'b0, acc[2*W-1:W]} + (b_q[0] ? {1'b0, a_q} : {(W+1){1'b0}});
    mul_acc   = {mul_sum, acc[W-1:1]};
    div_shift = {acc[W-1:0], a_q[W-1]};
    div_diff  = div_shift - {1'b0, b_q};
    div_ge    = ~div_diff[W];
    div_rem   = div_ge ? div_diff : div_shift;
    div_quo   = {a_q[W-2:0], div_ge};
    case (op_q)
      OP_MUL:   res_sel = mul_acc[W-1:0];
      OP_MULHU: res_sel = mul_acc[2*W-1:W];
      OP_DIVU:  res_sel = div_quo;
      default:  res_sel = div_rem[W-1:0];
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt         <= '0;
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      acc         <= '0;
      result      <= '0;
      div_by_zero <= 1'b0;
    end else if (accept) begin
      cnt  <= '0;
      op_q <= op;
      a_q  <= op_a;
      b_q  <= op_b;
      acc  <= '0;
    end else if (state == RUN) begin
      cnt <= cnt + 1'b1;
      if (op_q[1]) begin
        acc <= {{(W-1){1'b0}}, div_rem};
        a_q <= div_quo;
      end else begin
        acc <= mul_acc;
        b_q <= b_q >> 1;
      end
      if (last) begin
        result      <= res_sel;
        div_by_zero <= op_q[1] && (b_q == '0);
      end
    end
  end

endmodule

// File: tb/tb_mdu_iterative.sv
// Directed self-checking bench for mdu_iterative (DATAWIDTH = 32).
module tb_mdu_iterative;

  logic        clk;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        div_by_zero;

  int checks;
  int failures;

  mdu_iterative #(.DATAWIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .op_a(op_a), .op_b(op_b),
    .busy(busy), .done(done), .result(result), .div_by_zero(div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_res, input logic exp_dbz, input string name);
    int cyc;
    bit seen;
    op = o; op_a = a; op_b = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      failures++;
      $display("FAIL %s accept: busy=%b done=%b, required busy=1 done=0", name, busy, done);
    end
    cyc = 0; seen = 0;
    while (!seen && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
      if (done === 1'b1) seen = 1;
    end
    checks++;
    if (!seen || cyc != 32) begin
      failures++;
      $display("FAIL %s latency: got %0d cycles (seen=%0d), required 32", name, cyc, seen);
    end
    checks++;
    if (result !== exp_res) begin
      failures++;
      $display("FAIL %s result: got %h, required %h", name, result, exp_res);
    end
    checks++;
    if (div_by_zero !== exp_dbz || busy !== 1'b0) begin
      failures++;
      $display("FAIL %s flags: dbz=%b busy=%b, required dbz=%b busy=0", name, div_by_zero, busy, exp_dbz);
    end
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || result !== exp_res || div_by_zero !== exp_dbz) begin
      failures++;
      $display("FAIL %s hold: done=%b busy=%b result=%h dbz=%b, required 0 0 %h %b",
               name, done, busy, result, div_by_zero, exp_res, exp_dbz);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; op = 2'b10; op_a = 32'h1234_5678; op_b = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== 32'h0 || div_by_zero !== 1'b0) begin
      failures++;
      $display("FAIL reset: busy=%b done=%b result=%h dbz=%b, required all 0", busy, done, result, div_by_zero);
    end
    rst = 1'b0; start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || result !== 32'h0 || div_by_zero !== 1'b0) begin
        failures++;
        $display("FAIL reset_hold[%0d]: busy=%b done=%b result=%h dbz=%b, required all 0",
                 i, busy, done, result, div_by_zero);
      end
    end
  endtask

  task automatic test_mul();
    run_op(2'b00, 32'h0000_FFFF, 32'h0001_0001, 32'hFFFF_FFFF, 1'b0, "mul_a");
    run_op(2'b01, 32'h0000_FFFF, 32'h0001_0001, 32'h0000_0000, 1'b0, "mulhu_a");
    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, "mulhu_b");
    run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, "mul_b");
  endtask

  task automatic test_div();
    run_op(2'b10, 32'd100, 32'd7, 32'd14, 1'b0, "divu");
    run_op(2'b11, 32'd100, 32'd7, 32'd2, 1'b0, "remu");
    run_op(2'b10, 32'd5, 32'd0, 32'hFFFF_FFFF, 1'b1, "divu_zero");
    run_op(2'b11, 32'd5, 32'd0, 32'd5, 1'b1, "remu_zero");
    run_op(2'b11, 32'hFFFF_FFFF, 32'h0001_0000, 32'h0000_FFFF, 1'b0, "remu_big");
  endtask

  task automatic test_back_to_back();
    int cyc;
    int n;
    op = 2'b00; op_a = 32'd3; op_b = 32'd4; start = 1'b1;
    @(posedge clk); #1;
    cyc = 0; n = 0;
    while (n < 3 && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
      if (done === 1'b1) begin
        n++;
        checks++;
        if (cyc != 32 + 33 * (n - 1) || result !== 32'd12 || busy !== 1'b0) begin
          failures++;
          $display("FAIL b2b pulse %0d: cycle=%0d result=%h busy=%b, required cycle=%0d result=0000000c busy=0",
                   n, cyc, result, busy, 32 + 33 * (n - 1));
        end
      end
    end
    checks++;
    if (n != 3) begin
      failures++;
      $display("FAIL b2b count: got %0d pulses, required 3", n);
    end
    start = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL b2b drain: busy=%b done=%b, required 0 0", busy, done);
    end
  endtask

  task automatic test_mid_run_changes();
    int cyc;
    bit seen;
    op = 2'b00; op_a = 32'h0000_FFFF; op_b = 32'h0001_0001; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    op = 2'b10; op_a = 32'd1; op_b = 32'd0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 6; seen = 0;
    while (!seen && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
      if (done === 1'b1) seen = 1;
    end
    checks++;
    if (!seen || cyc != 32 || result !== 32'hFFFF_FFFF || div_by_zero !== 1'b0) begin
      failures++;
      $display("FAIL mid_run: cycle=%0d result=%h dbz=%b, required cycle=32 result=ffffffff dbz=0",
               cyc, result, div_by_zero);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_run();
    int cyc;
    bit seen;
    op = 2'b10; op_a = 32'd100; op_b = 32'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== 32'h0 || div_by_zero !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_run: busy=%b done=%b result=%h dbz=%b, required all 0",
               busy, done, result, div_by_zero);
    end
    rst = 1'b0;
    cyc = 0; seen = 0;
    while (cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
      if (done !== 1'b0 || busy !== 1'b0) seen = 1;
    end
    checks++;
    if (seen) begin
      failures++;
      $display("FAIL reset_abort: activity after abort seen=%0d, required 0", seen);
    end
    run_op(2'b00, 32'd3, 32'd4, 32'd12, 1'b0, "mul_after_reset");
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_mul();
    test_div();
    test_back_to_back();
    test_mid_run_changes();
    test_reset_mid_run();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
